// File: rtl/imem_loader_if.sv
// Loader-side port bundle for imem_loader: load control, byte stream handshake and status.
// The stream source drives through master; the loader sits on slave.
interface imem_loader_if #(
  parameter int AW = 5
);
  logic          load_start;
  logic [AW:0]   load_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          busy;
  logic          load_done;

  modport master (
    output load_start, load_words, byte_valid, byte_data,
    input  byte_ready, busy, load_done
  );

  modport slave (
    input  load_start, load_words, byte_valid, byte_data,
    output byte_ready, busy, load_done
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream loader (little-endian words from word 0) and an async fetch port.
// Optional: define IMEM_CHECKSUM_EN for a running 32-bit sum of the words written in the current load.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      lif,
  input  logic [AW-1:0]     rd_addr,
  output logic [31:0]       rd_data,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [1:0]    byte_cnt_q;
  logic [23:0]   shift_q;
  logic [AW:0]   count_q;
  logic [31:0]   mem [DEPTH];

  logic        start;
  logic        accept;
  logic        word_wr;
  logic        last_word;
  logic [31:0] wr_word;

  // A start request is only honoured outside LOAD; in DONE it also blocks any byte since ready is low.
  assign start     = lif.load_start && (state_q != S_LOAD);
  assign accept    = lif.byte_valid && lif.byte_ready;
  assign word_wr   = accept && (byte_cnt_q == 2'd3);
  assign last_word = (({1'b0, wr_ptr_q} + ONE_W) == count_q);
  assign wr_word   = {lif.byte_data, shift_q};

  assign lif.byte_ready = (state_q == S_LOAD);
  assign lif.busy       = (state_q == S_LOAD);
  assign lif.load_done  = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)                 state_d = S_LOAD;
      S_LOAD:  if (word_wr && last_word)  state_d = S_DONE;
      S_DONE:  if (start)                 state_d = S_LOAD;
      default:                            state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      count_q    <= DEPTH_W;
    end else if (start) begin
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      count_q    <= (lif.load_words == '0 || lif.load_words > DEPTH_W) ? DEPTH_W : lif.load_words;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      // Bytes enter at the top and slide down, so byte 0 ends up in [7:0] after three shifts.
      shift_q    <= {lif.byte_data, shift_q[23:8]};
      if (word_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  // NOTE: the memory array has no reset; loaded code must survive a reset and a RAM macro has none.
  always_ff @(posedge clk) begin
    if (word_wr) mem[wr_ptr_q] <= wr_word;
  end

  assign rd_data = mem[rd_addr];

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sum_q <= '0;
    else if (start)   sum_q <= '0;
    else if (word_wr) sum_q <= sum_q + wr_word;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, reset mid-load, ignored restarts, read-during-write, checksum.
module tb_imem_loader;

`ifdef IMEM_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  imem_loader_if #(.AW(5)) lif ();

  imem_loader #(.DEPTH(32), .AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .lif      (lif),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  function automatic logic [31:0] cs_exp(input logic [31:0] sum);
    return CS_EN ? sum : 32'h0;
  endfunction

  // Tasks start and end on a falling edge.
  task automatic start_load(input logic [5:0] n);
    lif.load_start = 1'b1;
    lif.load_words = n;
    @(negedge clk);
    lif.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!lif.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!lif.byte_ready) check("byte_ready_timeout", 32'(lif.byte_ready), 32'h1);
    lif.byte_valid = 1'b1;
    lif.byte_data  = b;
    @(negedge clk);
    lif.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    logic [31:0] sum;
    rst = 1'b1;
    lif.load_start = 1'b0;
    lif.load_words = '0;
    lif.byte_valid = 1'b0;
    lif.byte_data  = '0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",       32'(lif.busy),       32'h0);
    check("rst_load_done",  32'(lif.load_done),  32'h0);
    check("rst_byte_ready", 32'(lif.byte_ready), 32'h0);
    check("rst_checksum",   checksum,            32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered in IDLE are refused.
    lif.byte_valid = 1'b1;
    lif.byte_data  = 8'h5A;
    repeat (2) @(negedge clk);
    check("idle_no_ready", 32'(lif.byte_ready), 32'h0);
    check("idle_no_busy",  32'(lif.busy),       32'h0);
    lif.byte_valid = 1'b0;

    // Two-word load from the stream 13 00 00 00 93 00 10 00.
    start_load(6'd2);
    check("t1_busy",  32'(lif.busy),       32'h1);
    check("t1_ready", 32'(lif.byte_ready), 32'h1);
    send_word(32'h0000_0013, 0);
    check("t1_mid_busy", 32'(lif.busy), 32'h1);
    send_word(32'h0010_0093, 0);
    check("t1_done",       32'(lif.load_done),  32'h1);
    check("t1_ready_low",  32'(lif.byte_ready), 32'h0);
    check("t1_busy_low",   32'(lif.busy),       32'h0);
    rd_check("t1_mem0", 5'd0, 32'h0000_0013);
    rd_check("t1_mem1", 5'd1, 32'h0010_0093);
    check("t1_checksum", checksum, cs_exp(32'h0010_00A6));

    // Bytes offered in DONE are refused and change nothing.
    lif.byte_valid = 1'b1;
    lif.byte_data  = 8'hEE;
    repeat (3) @(negedge clk);
    lif.byte_valid = 1'b0;
    check("done_hold", 32'(lif.load_done), 32'h1);
    rd_check("done_mem0", 5'd0, 32'h0000_0013);

    // Checksum wraps to zero, then restarts from zero on the next load.
    start_load(6'd2);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    check("t6_cs_wrap", checksum, 32'h0);
    start_load(6'd1);
    check("t6_cs_clear", checksum, 32'h0);
    send_word(32'h0000_0005, 0);
    check("t6_cs_second", checksum, cs_exp(32'h0000_0005));
    rd_check("t6_mem0", 5'd0, 32'h0000_0005);

    // load_words=0 means full depth; random gaps between bytes.
    start_load(6'd0);
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      send_word(pat(i), 2);
      sum += pat(i);
      if (i == 30) check("t2_not_done_early", 32'(lif.load_done), 32'h0);
    end
    check("t2_done", 32'(lif.load_done), 32'h1);
    check("t2_checksum", checksum, cs_exp(sum));
    for (int i = 0; i < 32; i++) rd_check($sformatf("t2_mem%0d", i), 5'(i), pat(i));

    // Reset after 6 of 8 bytes: word 0 written, word 1 untouched, FSM idle.
    start_load(6'd2);
    send_word(32'h1122_3344, 0);
    send_byte(8'h88);
    send_byte(8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_busy",      32'(lif.busy),      32'h0);
    check("t3_load_done", 32'(lif.load_done), 32'h0);
    check("t3_ready",     32'(lif.byte_ready), 32'h0);
    check("t3_checksum",  checksum,           32'h0);
    rd_check("t3_mem0", 5'd0, 32'h1122_3344);
    rd_check("t3_mem1", 5'd1, pat(1));

    // load_start mid-LOAD is ignored; the word assembles from its original bytes.
    start_load(6'd1);
    send_byte(8'h0D);
    send_byte(8'hF0);
    start_load(6'd5);
    send_byte(8'hFE);
    send_byte(8'hCA);
    check("t4_done", 32'(lif.load_done), 32'h1);
    rd_check("t4_mem0", 5'd0, 32'hCAFE_F00D);

    // Read-during-write: rd_data shows the old word until the writing edge.
    start_load(6'd2);
    send_word(32'h0102_0304, 0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    rd_addr = 5'd1;
    lif.byte_valid = 1'b1;
    lif.byte_data  = 8'hDE;
    #1;
    check("t5_old", rd_data, pat(1));
    @(negedge clk);
    lif.byte_valid = 1'b0;
    #1;
    check("t5_new", rd_data, 32'hDEAD_BEEF);
    check("t5_done", 32'(lif.load_done), 32'h1);

    // Start coincident with an offered byte in DONE: start wins, the byte is not taken.
    lif.byte_valid = 1'b1;
    lif.byte_data  = 8'h77;
    start_load(6'd1);
    lif.byte_valid = 1'b0;
    check("t7_busy", 32'(lif.busy), 32'h1);
    send_word(32'h4433_2211, 0);
    check("t7_done", 32'(lif.load_done), 32'h1);
    rd_check("t7_mem0", 5'd0, 32'h4433_2211);
    rd_check("t7_mem1", 5'd1, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
